// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM command-port arbiter: bus widths,
// command encoding and the arbiter state encoding.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 21;
  localparam int PSRAM_DATA_W = 64;
  localparam int PSRAM_MASK_W = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/psram_arbiter.sv
// Arbiter between a framebuffer writer and a framebuffer reader driving the
// PSRAM IP command/data port. Serialises commands, keeps cmd_en strobes at
// least CMD_CYCLES apart, streams write beats and registers read returns.
// Optional build macro: PSRAM_ARB_ROUND_ROBIN_EN -- alternate priority on
// read/write ties; otherwise reads always win.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int BURST_BEATS = 4,
  parameter int CMD_CYCLES  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_write_req,
  output logic                    o_write_gnt,
  input  logic [PSRAM_ADDR_W-1:0] i_write_addr,
  input  logic [PSRAM_DATA_W-1:0] i_write_data,
  input  logic [PSRAM_MASK_W-1:0] i_write_data_mask,
  input  logic                    i_read_req,
  output logic                    o_read_gnt,
  input  logic [PSRAM_ADDR_W-1:0] i_read_addr,
  output logic [PSRAM_DATA_W-1:0] o_read_data,
  output logic                    o_read_data_valid,
  input  logic                    i_psram_init_calib,
  output logic                    o_psram_cmd,
  output logic                    o_psram_cmd_en,
  output logic [PSRAM_ADDR_W-1:0] o_psram_addr,
  output logic [PSRAM_DATA_W-1:0] o_psram_wr_data,
  output logic [PSRAM_MASK_W-1:0] o_psram_data_mask,
  input  logic [PSRAM_DATA_W-1:0] i_psram_rd_data,
  input  logic                    i_psram_rd_data_valid
);

  localparam int                CNT_W     = $clog2(CMD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(CMD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  arb_state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_gap_cnt, w_gap_cnt_nxt;
  logic [CNT_W-1:0]        r_beat, w_beat_nxt;
  logic                    r_cmd_en, w_cmd_en_nxt;
  logic                    r_cmd, w_cmd_nxt;
  logic [PSRAM_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic                    r_read_gnt, w_read_gnt_nxt;
  logic [PSRAM_DATA_W-1:0] r_rd_data;
  logic                    r_rd_valid;
  logic                    w_issue;
  logic                    w_pick_read;

  // A command may be issued from IDLE, or from the final GAP cycle so that
  // back-to-back commands land exactly CMD_CYCLES apart.
  assign w_issue = ((r_state == IDLE) || (r_state == GAP)) && i_psram_init_calib &&
                   (r_gap_cnt == '0) && (i_read_req || i_write_req);

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  logic r_last_write;

  // Remember which class was served last; starts as "write" so a read wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_write <= 1'b1;
    end else if (w_issue) begin
      r_last_write <= !w_pick_read;
    end
  end

  assign w_pick_read = i_read_req && (!i_write_req || r_last_write);
`else
  assign w_pick_read = i_read_req;
`endif

  // State, counters and registered command outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= INIT;
      r_gap_cnt  <= '0;
      r_beat     <= '0;
      r_cmd_en   <= 1'b0;
      r_cmd      <= CMD_READ;
      r_addr     <= '0;
      r_read_gnt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_beat     <= w_beat_nxt;
      r_cmd_en   <= w_cmd_en_nxt;
      r_cmd      <= w_cmd_nxt;
      r_addr     <= w_addr_nxt;
      r_read_gnt <= w_read_gnt_nxt;
    end
  end

  // Next-state, beat/gap counting and command issue.
  always_comb begin
    w_state_nxt    = r_state;
    w_gap_cnt_nxt  = (r_gap_cnt != '0) ? (r_gap_cnt - 1'b1) : '0;
    w_beat_nxt     = '0;
    w_cmd_en_nxt   = 1'b0;
    w_cmd_nxt      = CMD_READ;
    w_addr_nxt     = '0;
    w_read_gnt_nxt = 1'b0;

    case (r_state)
      INIT: begin
        if (i_psram_init_calib) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE, GAP: begin
        if (!i_psram_init_calib) begin
          w_state_nxt = INIT;
        end else if (w_issue) begin
          w_state_nxt = w_pick_read ? GAP : WRITE;
        end else if ((r_state == GAP) && (r_gap_cnt == '0)) begin
          w_state_nxt = IDLE;
        end
      end
      WRITE: begin
        // A started burst always finishes; calib loss only redirects the exit.
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = i_psram_init_calib ? GAP : INIT;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      default: w_state_nxt = INIT;
    endcase

    if (w_issue && i_psram_init_calib) begin
      w_cmd_en_nxt   = 1'b1;
      w_gap_cnt_nxt  = GAP_LOAD;
      w_cmd_nxt      = w_pick_read ? CMD_READ : CMD_WRITE;
      w_addr_nxt     = w_pick_read ? i_read_addr : i_write_addr;
      w_read_gnt_nxt = w_pick_read;
    end
  end

  // Read return path: one-cycle register, active in every state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_data  <= i_psram_rd_data;
      r_rd_valid <= i_psram_rd_data_valid;
    end
  end

  assign o_psram_cmd_en    = r_cmd_en;
  assign o_psram_cmd       = r_cmd;
  assign o_psram_addr      = r_addr;
  assign o_read_gnt        = r_read_gnt;
  assign o_write_gnt       = (r_state == WRITE);
  assign o_psram_wr_data   = o_write_gnt ? i_write_data : '0;
  assign o_psram_data_mask = o_write_gnt ? i_write_data_mask : '0;
  assign o_read_data       = r_rd_data;
  assign o_read_data_valid = r_rd_valid;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: calib gating, single write burst,
// table of arbitration vectors (back-to-back reads and contention),
// read-return scoreboard and reset during a write burst.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_write_req, i_read_req, i_calib, i_rd_valid;
  logic [20:0] i_write_addr, i_read_addr;
  logic [63:0] i_write_data, i_rd_data;
  logic [7:0]  i_mask;
  logic        o_write_gnt, o_read_gnt, o_read_data_valid, o_cmd, o_cmd_en;
  logic [63:0] o_read_data, o_wr_data;
  logic [20:0] o_addr;
  logic [7:0]  o_mask;

  always #5 clk = ~clk;

  psram_arbiter #(.BURST_BEATS(4), .CMD_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_write_req(i_write_req), .o_write_gnt(o_write_gnt),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .i_write_data_mask(i_mask),
    .i_read_req(i_read_req), .o_read_gnt(o_read_gnt), .i_read_addr(i_read_addr),
    .o_read_data(o_read_data), .o_read_data_valid(o_read_data_valid),
    .i_psram_init_calib(i_calib), .o_psram_cmd(o_cmd), .o_psram_cmd_en(o_cmd_en),
    .o_psram_addr(o_addr), .o_psram_wr_data(o_wr_data), .o_psram_data_mask(o_mask),
    .i_psram_rd_data(i_rd_data), .i_psram_rd_data_valid(i_rd_valid)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned ncyc  = 0;
  int unsigned ncmd  = 0;
  int unsigned ngnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (o_cmd_en) ncmd++;
    if (o_read_gnt || o_write_gnt) ngnt++;
  end

  // Read-return scoreboard: expected beat and the cycle it must appear.
  typedef struct { logic [63:0] data; int unsigned due; } rret_t;
  rret_t rq[$];

  always @(negedge clk) begin
    rret_t e;
    if (o_read_data_valid) begin
      if (rq.size() == 0) begin
        chk("rd_valid_unexpected", 64'd1, 64'd0);
      end else begin
        e = rq.pop_front();
        chk("rd_data", o_read_data, e.data);
        chk("rd_latency", 64'(ncyc), 64'(e.due));
      end
    end
  end

  task automatic wait_cmd(input int unsigned budget, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_cmd_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cmd_en_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [20:0] ra;
    logic [20:0] wa;
    logic        ecmd;
    logic [20:0] eaddr;
    logic        chk_gap;
  } vec_t;

  vec_t        vt[10];
  logic        ok;
  int unsigned last_cyc;
  int unsigned snap;
  rret_t       r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 21'd0,      21'd0,      1'b0, 21'd0,      1'b0};
    vt[1] = '{1'b1, 1'b0, 21'd4,      21'd0,      1'b0, 21'd4,      1'b1};
    vt[2] = '{1'b1, 1'b0, 21'd8,      21'd0,      1'b0, 21'd8,      1'b1};
    vt[3] = '{1'b1, 1'b0, 21'd12,     21'd0,      1'b0, 21'd12,     1'b1};
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    vt[4] = '{1'b1, 1'b1, 21'h01000, 21'h02000, 1'b1, 21'h02000, 1'b1};
    vt[5] = '{1'b1, 1'b1, 21'h01004, 21'h02004, 1'b0, 21'h01004, 1'b1};
    vt[6] = '{1'b1, 1'b1, 21'h01008, 21'h02008, 1'b1, 21'h02008, 1'b1};
    vt[7] = '{1'b1, 1'b1, 21'h0100c, 21'h0200c, 1'b0, 21'h0100c, 1'b1};
`else
    vt[4] = '{1'b1, 1'b1, 21'h01000, 21'h02000, 1'b0, 21'h01000, 1'b1};
    vt[5] = '{1'b1, 1'b1, 21'h01004, 21'h02004, 1'b0, 21'h01004, 1'b1};
    vt[6] = '{1'b1, 1'b1, 21'h01008, 21'h02008, 1'b0, 21'h01008, 1'b1};
    vt[7] = '{1'b1, 1'b1, 21'h0100c, 21'h0200c, 1'b0, 21'h0100c, 1'b1};
`endif
    vt[8] = '{1'b0, 1'b1, 21'h0, 21'h03000, 1'b1, 21'h03000, 1'b1};
    vt[9] = '{1'b1, 1'b0, 21'h00777, 21'h0, 1'b0, 21'h00777, 1'b1};

    rst_n = 1'b0; i_calib = 1'b0; i_write_req = 1'b0; i_read_req = 1'b0;
    i_write_addr = '0; i_read_addr = '0; i_write_data = '0; i_mask = '0;
    i_rd_data = '0; i_rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_cmd_en", 64'(o_cmd_en), 64'd0);
    chk("rst_gnts", 64'({o_read_gnt, o_write_gnt}), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_wr_data", o_wr_data, 64'd0);
    chk("rst_mask", 64'(o_mask), 64'd0);
    chk("rst_rd_valid", 64'(o_read_data_valid), 64'd0);

    // Calib gating, with read returns forwarded while still in INIT
    i_read_req = 1'b1; i_read_addr = 21'h00155;
    snap = ncmd + ngnt;
    for (int unsigned k = 1; k <= 4; k++) begin
      i_rd_valid = 1'b1; i_rd_data = 64'(k);
      r.data = 64'(k); r.due = ncyc + 1; rq.push_back(r);
      @(negedge clk);
    end
    i_rd_valid = 1'b0; i_rd_data = 64'hdead;
    repeat (96) @(negedge clk);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("init_no_cmd", 64'(ncmd + ngnt - snap), 64'd0);

    i_calib = 1'b1;
    @(negedge clk);
    chk("idle_entry_no_cmd", 64'(o_cmd_en), 64'd0);
    wait_cmd(3, ok);
    if (ok) begin
      chk("calib_cmd", 64'(o_cmd), 64'd0);
      chk("calib_addr", 64'(o_addr), 64'h155);
      chk("calib_read_gnt", 64'(o_read_gnt), 64'd1);
    end
    i_read_req = 1'b0;
    @(negedge clk);
    chk("read_gnt_pulse", 64'(o_read_gnt), 64'd0);
    repeat (20) @(negedge clk);

    // Single write burst, data advancing after each grant
    i_write_req = 1'b1; i_write_addr = 21'd12345;
    i_write_data = 64'h0123_4567_89ab_cdef; i_mask = 8'h5a;
    wait_cmd(5, ok);
    if (ok) begin
      chk("wr_cmd", 64'(o_cmd), 64'd1);
      chk("wr_addr", 64'(o_addr), 64'd12345);
      for (int unsigned k = 0; k < 4; k++) begin
        if (k != 0) @(negedge clk);
        chk("wr_gnt", 64'(o_write_gnt), 64'd1);
        chk("wr_data", o_wr_data, 64'h0123_4567_89ab_cdef + 64'(k));
        chk("wr_mask", 64'(o_mask), 64'(8'h5a ^ 8'(k)));
        i_write_req  = 1'b0;
        i_write_data = 64'h0123_4567_89ab_cdef + 64'(k + 1);
        i_mask       = 8'h5a ^ 8'(k + 1);
      end
      @(negedge clk);
      chk("wr_gnt_end", 64'(o_write_gnt), 64'd0);
      chk("wr_data_idle", o_wr_data, 64'd0);
      chk("wr_mask_idle", 64'(o_mask), 64'd0);
    end
    i_write_req = 1'b0;

    // Arbitration vectors: back-to-back reads, contention, single requests
    last_cyc = ncyc;
    for (int i = 0; i < 10; i++) begin
      i_read_req = vt[i].rd; i_write_req = vt[i].wr;
      i_read_addr = vt[i].ra; i_write_addr = vt[i].wa;
      wait_cmd(40, ok);
      if (ok) begin
        chk("vec_cmd", 64'(o_cmd), 64'(vt[i].ecmd));
        chk("vec_addr", 64'(o_addr), 64'(vt[i].eaddr));
        if (vt[i].chk_gap) chk("vec_spacing", 64'(ncyc - last_cyc), 64'd16);
        last_cyc = ncyc;
      end
    end
    i_read_req = 1'b0; i_write_req = 1'b0;
    repeat (20) @(negedge clk);

    // Reset asserted during the second write beat
    i_write_req = 1'b1; i_write_addr = 21'd7;
    wait_cmd(5, ok);
    @(negedge clk);
    chk("beat2_gnt", 64'(o_write_gnt), 64'd1);
    rst_n = 1'b0; i_calib = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 64'({o_read_gnt, o_write_gnt}), 64'd0);
    chk("mid_rst_cmd_en", 64'(o_cmd_en), 64'd0);
    chk("mid_rst_wr_data", o_wr_data, 64'd0);
    chk("mid_rst_mask", 64'(o_mask), 64'd0);
    rst_n = 1'b1;
    snap = ncmd;
    repeat (10) @(negedge clk);
    chk("post_rst_no_cmd", 64'(ncmd - snap), 64'd0);
    i_calib = 1'b1;
    wait_cmd(4, ok);
    if (ok) begin
      chk("post_rst_cmd", 64'(o_cmd), 64'd1);
      chk("post_rst_addr", 64'(o_addr), 64'd7);
    end
    i_write_req = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
